key_weight_replay_cache: RTL and testbench
==========================================

Name: key_weight_replay_cache

Overview:
- Sits directly downstream of the key-weight parameter ROM source, between it and the key-projection linear stage.
- Captures one full weight tensor streamed from the source (one pass of DEPTH beats), forwarding it as it arrives.
- Then replays the stored tensor REPEAT-1 more times from local storage, so the linear stage gets one weight pass per token without re-reading the ROM.
- After the final replay it returns to loading and accepts the next tensor.

Parameters:
- PRECISION_0, 16, total bits per weight element.
- PRECISION_1, 3, fractional bits; carried for typing only, no arithmetic performed.
- TENSOR_SIZE_DIM_0, 32, tensor columns.
- TENSOR_SIZE_DIM_1, 1, tensor rows.
- PARALLELISM_DIM_0, 1, elements per beat, dim 0.
- PARALLELISM_DIM_1, 1, elements per beat, dim 1.
- PAR, PARALLELISM_DIM_0*PARALLELISM_DIM_1, elements per beat (derived).
- DEPTH, (TENSOR_SIZE_DIM_0*TENSOR_SIZE_DIM_1)/PAR, beats per pass (derived, >=2).
- REPEAT, 4, total passes emitted per loaded tensor (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- data_in  in  PRECISION_0 x PAR (unpacked array)  weight beat from source.
- data_in_valid  in  1  source beat valid.
- data_in_ready  out  1  cache accepts beat.
- data_out  out  PRECISION_0 x PAR  weight beat to consumer.
- data_out_valid  out  1  output beat valid.
- data_out_ready  in  1  consumer accepts beat.
- data_out_last  out  1  high with the last beat (index DEPTH-1) of each pass.
- replaying  out  1  high while in REPLAY state.

Behaviour:
- Storage: DEPTH x (PAR*PRECISION_0) register array, combinational read, written only in LOAD.
- Output stage: single register (data_out, data_out_last, data_out_valid).
  - adv = !data_out_valid || data_out_ready.
  - When adv and no new beat is produced, data_out_valid <= 0.
  - Output holds stable while valid && !ready.
- Counters:
  - ptr, 0..DEPTH-1.
  - pass_cnt, 0..REPEAT-1.
- State LOAD (reset state):
  - data_in_ready = adv.
  - On data_in_valid && data_in_ready: mem[ptr] <= data_in; out reg <= data_in; data_out_valid <= 1; data_out_last <= (ptr==DEPTH-1).
  - ptr increments on each accepted beat.
  - At ptr==DEPTH-1: ptr <= 0. If REPEAT>1, go to REPLAY with pass_cnt <= 1; else remain in LOAD.
- State REPLAY:
  - data_in_ready = 0.
  - On adv: out reg <= mem[ptr]; data_out_valid <= 1; data_out_last <= (ptr==DEPTH-1); ptr increments.
  - At ptr==DEPTH-1: ptr <= 0. If pass_cnt==REPEAT-1, go to LOAD with pass_cnt <= 0; else pass_cnt increments.
- Latency: 1 cycle from accepted input (LOAD) or state advance (REPLAY) to data_out_valid.
- Throughput: 1 beat/cycle under full ready; no bubble at the LOAD->REPLAY or REPLAY->LOAD boundary.
- replaying = (state==REPLAY), combinational from state.
- Reset values: data_out_valid=0, data_out_last=0, data_out=0, state=LOAD, ptr=0, pass_cnt=0. data_in_ready goes high the first cycle after reset.
- Reset mid-pass: partial tensor is discarded; the next accepted beat is written to index 0. Memory contents are not cleared.
- data_in_valid while in REPLAY: ignored, not consumed; upstream holds.

Optional Feature:
- Macro: KEY_WEIGHT_REPLAY_PERSIST_EN.
- Defined:
  - After the first complete load, the block stays in REPLAY indefinitely (pass_cnt frozen, REPEAT ignored after the first load).
  - data_in_ready stays 0 until rst.
  - Intended for static weights, so the ROM is read once.
- Undefined: LOAD/REPLAY cycling exactly as above.

Test Plan:
1. Defaults, REPEAT=4, source beat k = k+1, consumer always ready -> 128 output beats, values 1..32 repeated 4 times. data_out_last on outputs 32/64/96/128. data_in_ready low for exactly 96 cycles. The next tensor (100+k) follows with no bubble.
2. Random data_out_ready (50%) with continuous source -> no beat lost or duplicated, data_out stable while stalled. Sequence matches scenario 1, and data_in_ready is never high while data_out_valid && !data_out_ready.
3. REPEAT=1 -> pure pass-through: replaying never asserts, latency 1 cycle, data_in_ready == adv every cycle.
4. rst asserted at second replay pass, beat 10 -> next cycle data_out_valid=0, replaying=0, data_in_ready=1. A new load of 200+k emits 201.. starting at index 0.
5. data_in_valid held high during REPLAY -> data_in_ready=0 throughout; the first beat accepted after returning to LOAD is the held beat.
6. KEY_WEIGHT_REPLAY_PERSIST_EN defined, REPEAT=4 -> after load, 1..32 repeats for 10 passes with no return to LOAD, and data_in_ready stays 0.

Source files
------------

// File: rtl/key_weight_replay_cache.sv
// key_weight_replay_cache
// Captures one key-weight tensor from the parameter ROM stream, forwarding each
// beat as it arrives. It then replays the stored tensor REPEAT-1 more times
// from local registers, so the key-projection stage gets one weight pass per
// token. After the last replay it goes back to loading the next tensor.
// Optional build macro: KEY_WEIGHT_REPLAY_PERSIST_EN. When it is defined, the
// block loads once and then replays forever until rst, for static weights.
module key_weight_replay_cache #(
    parameter int PRECISION_0       = 16,
    parameter int PRECISION_1       = 3,
    parameter int TENSOR_SIZE_DIM_0 = 32,
    parameter int TENSOR_SIZE_DIM_1 = 1,
    parameter int PARALLELISM_DIM_0 = 1,
    parameter int PARALLELISM_DIM_1 = 1,
    parameter int PAR               = PARALLELISM_DIM_0 * PARALLELISM_DIM_1,
    parameter int DEPTH             = (TENSOR_SIZE_DIM_0 * TENSOR_SIZE_DIM_1) / PAR,
    parameter int REPEAT            = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PRECISION_0-1:0] data_in [PAR],
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    output logic [PRECISION_0-1:0] data_out [PAR],
    output logic                   data_out_valid,
    input  logic                   data_out_ready,
    output logic                   data_out_last,
    output logic                   replaying
);

    localparam int WORD_W = PAR * PRECISION_0;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
`ifndef KEY_WEIGHT_REPLAY_PERSIST_EN
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(REPEAT - 1);
`endif

    // Parameter sanity: these configurations cannot be built meaningfully.
    if (DEPTH < 2) begin : g_depth_chk
        $error("key_weight_replay_cache: DEPTH must be at least 2");
    end
    if (REPEAT < 1) begin : g_repeat_chk
        $error("key_weight_replay_cache: REPEAT must be at least 1");
    end
    if (PRECISION_1 > PRECISION_0) begin : g_frac_chk
        $error("key_weight_replay_cache: fractional bits exceed element width");
    end

    typedef enum logic {
        S_LOAD   = 1'b0,
        S_REPLAY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;

    logic [WORD_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [WORD_W-1:0]   in_word;
    logic                adv;

    // Flatten the incoming beat into one storage word.
    always_comb begin
        in_word = '0;
        for (int i = 0; i < PAR; i++) begin
            in_word[i*PRECISION_0 +: PRECISION_0] = data_in[i];
        end
    end

    // Next-state, counter and output-register logic for the LOAD/REPLAY FSM.
    always_comb begin
        adv           = !out_valid_q || data_out_ready;
        state_d       = state_q;
        ptr_d         = ptr_q;
        pass_d        = pass_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        out_valid_d   = adv ? 1'b0 : out_valid_q;
        mem_we        = 1'b0;
        data_in_ready = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                data_in_ready = adv;
                if (data_in_valid && adv) begin
                    mem_we      = 1'b1;
                    out_data_d  = in_word;
                    out_valid_d = 1'b1;
                    out_last_d  = (ptr_q == PTR_LAST);
                    if (ptr_q == PTR_LAST) begin
                        ptr_d = '0;
`ifdef KEY_WEIGHT_REPLAY_PERSIST_EN
                        state_d = S_REPLAY;
`else
                        if (REPEAT > 1) begin
                            state_d = S_REPLAY;
                            pass_d  = PASS_W'(1);
                        end
`endif
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end

            S_REPLAY: begin
                if (adv) begin
                    out_data_d  = mem_q[ptr_q];
                    out_valid_d = 1'b1;
                    out_last_d  = (ptr_q == PTR_LAST);
                    if (ptr_q == PTR_LAST) begin
                        ptr_d = '0;
`ifndef KEY_WEIGHT_REPLAY_PERSIST_EN
                        if (pass_q == PASS_LAST) begin
                            state_d = S_LOAD;
                            pass_d  = '0;
                        end else begin
                            pass_d = pass_q + PASS_W'(1);
                        end
`endif
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State, counters and output register; reset discards any partial tensor.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            ptr_q       <= '0;
            pass_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pass_q      <= pass_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Weight storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= in_word;
        end
    end

    // Unpack the output register onto the per-element output port.
    always_comb begin
        for (int i = 0; i < PAR; i++) begin
            data_out[i] = out_data_q[i*PRECISION_0 +: PRECISION_0];
        end
    end

    assign data_out_valid = out_valid_q;
    assign data_out_last  = out_last_q;
    assign replaying      = (state_q == S_REPLAY);

endmodule

// File: tb/tb_key_weight_replay_cache.sv
// Testbench for key_weight_replay_cache.
// The main instance uses the default configuration (REPEAT=4) and is checked
// against a stream-level model: the output stream is every loaded tensor
// repeated REPEAT times. A second instance with REPEAT=1 is checked as a
// plain one-deep pass-through register.
module tb_key_weight_replay_cache;

   localparam int DEPTH = 32;
   localparam int REP   = 4;

   logic        clk;
   logic        rst;
   logic [15:0] dataIn [1];
   logic        dataInValid;
   logic        dataInReady;
   logic [15:0] dataOut [1];
   logic        dataOutValid;
   logic        dataOutReady;
   logic        dataOutLast;
   logic        replayingOut;

   logic        rstP;
   logic [15:0] dataInP [1];
   logic        dataInValidP;
   logic        dataInReadyP;
   logic [15:0] dataOutP [1];
   logic        dataOutValidP;
   logic        dataOutReadyP;
   logic        dataOutLastP;
   logic        replayingP;

   int testsRun    = 0;
   int testsFailed = 0;
   bit ptDone      = 0;

   // Model state for the main instance.
   logic [15:0] srcVals [$];
   logic [15:0] accLog  [$];
   int          srcPtr;
   int          consumed;
   bit          prevStall;
   logic [15:0] prevData;
   int          readyLowCount;
   int          bubbleCount;
   bit          checkFirst;
   logic [15:0] firstExpect;

   key_weight_replay_cache #(.REPEAT(REP)) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (dataIn),
      .data_in_valid  (dataInValid),
      .data_in_ready  (dataInReady),
      .data_out       (dataOut),
      .data_out_valid (dataOutValid),
      .data_out_ready (dataOutReady),
      .data_out_last  (dataOutLast),
      .replaying      (replayingOut)
   );

   key_weight_replay_cache #(.REPEAT(1)) dutPass (
      .clk            (clk),
      .rst            (rstP),
      .data_in        (dataInP),
      .data_in_valid  (dataInValidP),
      .data_in_ready  (dataInReadyP),
      .data_out       (dataOutP),
      .data_out_valid (dataOutValidP),
      .data_out_ready (dataOutReadyP),
      .data_out_last  (dataOutLastP),
      .replaying      (replayingP)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts one comparison and reports it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Replay expectation from counts: a fully loaded tensor whose REPEAT passes
   // have not all been produced yet means the block is replaying.
   function automatic bit replayExpected(input int accIn, input int produced);
`ifdef KEY_WEIGHT_REPLAY_PERSIST_EN
      return accIn >= DEPTH;
`else
      return (accIn > 0) && (accIn % DEPTH == 0) && (produced < (accIn / DEPTH) * REP * DEPTH);
`endif
   endfunction

   // Drive one cycle on the main instance, check everything visible before the
   // edge, then advance the model by whatever handshakes happened on the edge.
   task automatic applyStimulus(input bit wantValid, input bit outReady);
      bit inFire;
      bit outFire;
      bit expReplay;
      int n;
      int idx;
      dataInValid  = wantValid && (srcPtr < srcVals.size());
      dataIn[0]    = (srcPtr < srcVals.size()) ? srcVals[srcPtr] : 16'd0;
      dataOutReady = outReady;
      #1;
      if (prevStall) begin
         checkOutput("stall_hold_valid", 32'(dataOutValid), 32'd1);
         checkOutput("stall_hold_data", 32'(dataOut[0]), 32'(prevData));
      end
      expReplay = replayExpected(accLog.size(), consumed + int'(dataOutValid));
      checkOutput("replaying", 32'(replayingOut), 32'(expReplay));
      checkOutput("in_ready_rule", 32'(dataInReady), 32'(!expReplay && (!dataOutValid || outReady)));
      if (!dataInReady) readyLowCount++;
      if (!dataOutValid) bubbleCount++;
      inFire  = dataInValid && dataInReady;
      outFire = dataOutValid && dataOutReady;
      if (outFire) begin
         n = consumed;
`ifdef KEY_WEIGHT_REPLAY_PERSIST_EN
         idx = n % DEPTH;
`else
         idx = (n / (DEPTH * REP)) * DEPTH + (n % DEPTH);
`endif
         if (idx < accLog.size())
            checkOutput("out_data", 32'(dataOut[0]), 32'(accLog[idx]));
         else
            checkOutput("out_extra_beat", 32'(idx), 32'(accLog.size()));
         checkOutput("out_last", 32'(dataOutLast), 32'((n % DEPTH) == DEPTH - 1));
         if (checkFirst) begin
            checkOutput("first_after_reset", 32'(dataOut[0]), 32'(firstExpect));
            checkFirst = 1'b0;
         end
      end
      prevStall = dataOutValid && !dataOutReady;
      prevData  = dataOut[0];
      @(posedge clk);
      #1;
      if (inFire) begin
         accLog.push_back(dataIn[0]);
         srcPtr++;
      end
      if (outFire) consumed++;
   endtask

   // Clears the model and queues a fresh source stream: first tensor base+1..,
   // then random tensors.
   task automatic resetModel(input int base, input int tensors);
      accLog.delete();
      srcVals.delete();
      srcPtr    = 0;
      consumed  = 0;
      prevStall = 1'b0;
      for (int k = 0; k < DEPTH; k++) srcVals.push_back(16'(base + k + 1));
      for (int t = 1; t < tensors; t++)
         for (int k = 0; k < DEPTH; k++) srcVals.push_back(16'($urandom));
   endtask

   // Main instance sequence: reset, full-rate run, random back-pressure, mid-replay reset.
   initial begin
      bit reached;
      rst          = 1'b1;
      dataInValid  = 1'b0;
      dataOutReady = 1'b0;
      dataIn[0]    = 16'd0;
      checkFirst   = 1'b0;
      firstExpect  = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_valid", 32'(dataOutValid), 32'd0);
      checkOutput("reset_last", 32'(dataOutLast), 32'd0);
      checkOutput("reset_data", 32'(dataOut[0]), 32'd0);
      checkOutput("reset_replaying", 32'(replayingOut), 32'd0);
      rst = 1'b0;

      // Full rate: tensor 1..32 then 100..131, continuous source and sink.
      resetModel(0, 12);
      for (int k = 0; k < DEPTH; k++) srcVals[DEPTH + k] = 16'(100 + k);
      readyLowCount = 0;
      bubbleCount   = 0;
      for (int c = 0; c < 160; c++) begin
         applyStimulus(1'b1, 1'b1);
         if (c == 0) bubbleCount = 0;
         if (c == 127) checkOutput("ready_low_cycles", 32'(readyLowCount), 32'(DEPTH * (REP - 1)));
      end
      checkOutput("no_bubbles", 32'(bubbleCount), 32'd0);

      // Random sink back-pressure with a mostly continuous source.
      for (int c = 0; c < 700; c++)
         applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1);

      // Reset at beat 10 of the second replay pass of a fresh tensor.
      rst = 1'b1;
      dataInValid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      resetModel(20, 2);
      reached = 1'b0;
      for (int c = 0; c < 400 && !reached; c++) begin
         applyStimulus(1'b1, 1'b1);
         if (consumed == 2 * DEPTH + 10) reached = 1'b1;
      end
      if (!reached) checkOutput("reset_point_timeout", 32'(consumed), 32'(2 * DEPTH + 10));
      dataInValid  = 1'b0;
      dataOutReady = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("midreset_valid", 32'(dataOutValid), 32'd0);
      checkOutput("midreset_replaying", 32'(replayingOut), 32'd0);
      checkOutput("midreset_in_ready", 32'(dataInReady), 32'd1);
      @(posedge clk);
      #1;
      // The cycle above was an idle cycle with no source beat offered.
      resetModel(200, 3);
      checkFirst  = 1'b1;
      firstExpect = 16'd201;
      for (int c = 0; c < 300; c++) applyStimulus(1'b1, 1'b1);
      if (checkFirst) checkOutput("first_after_reset_seen", 32'(checkFirst), 32'd0);

      for (int i = 0; i < 2000 && !ptDone; i++) @(posedge clk);
      if (!ptDone) checkOutput("pass_through_timeout", 32'(ptDone), 32'd1);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // REPEAT=1 instance: every accepted beat appears on the output one cycle later.
   initial begin
      logic [15:0] ptQ [$];
      logic [15:0] ptLastIn;
      bit          ptExpectNew;
      bit          fire;
      rstP          = 1'b1;
      dataInValidP  = 1'b0;
      dataOutReadyP = 1'b0;
      dataInP[0]    = 16'd0;
      ptLastIn      = 16'd0;
      ptExpectNew   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstP = 1'b0;
`ifndef KEY_WEIGHT_REPLAY_PERSIST_EN
      for (int c = 0; c < 300; c++) begin
         dataInValidP  = $urandom_range(0, 1) == 1;
         dataInP[0]    = 16'($urandom);
         dataOutReadyP = $urandom_range(0, 1) == 1;
         #1;
         if (ptExpectNew) begin
            checkOutput("pt_latency_valid", 32'(dataOutValidP), 32'd1);
            checkOutput("pt_latency_data", 32'(dataOutP[0]), 32'(ptLastIn));
         end
         checkOutput("pt_replaying", 32'(replayingP), 32'd0);
         checkOutput("pt_in_ready", 32'(dataInReadyP), 32'(!dataOutValidP || dataOutReadyP));
         if (dataOutValidP && dataOutReadyP) begin
            if (ptQ.size() > 0)
               checkOutput("pt_data", 32'(dataOutP[0]), 32'(ptQ.pop_front()));
            else
               checkOutput("pt_extra_beat", 32'(ptQ.size()), 32'd1);
         end
         fire = dataInValidP && dataInReadyP;
         if (fire) begin
            ptQ.push_back(dataInP[0]);
            ptLastIn = dataInP[0];
         end
         ptExpectNew = fire;
         @(posedge clk);
         #1;
      end
`endif
      ptDone = 1'b1;
   end

endmodule
